// File: rtl/ddr_wr_buf.sv
// ddr_wr_buf: packs RGB565 pixels into DQ_WIDTH*8-bit words, buffers them in a
// word FIFO and hands them to an AXI write master as fixed-length bursts with
// incrementing DDR byte addresses that wrap at the end of each frame.
module ddr_wr_buf #(
   parameter int DQ_WIDTH   = 32,
   parameter int H_WIDTH    = 1280,
   parameter int H_HEIGHT   = 720,
   parameter int BURST_LEN  = 16,
   parameter int FIFO_DEPTH = 64,
   parameter int ADDR_W     = 28,
   parameter int FRAME_BASE = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    vsync_i,
   input  logic                    pix_valid,
   input  logic [15:0]             pix_data,
   output logic                    axi_wr_req,
   output logic [ADDR_W-1:0]       axi_wr_addr,
   input  logic                    axi_wr_ack,
   input  logic                    buf_rd_en,
   output logic [DQ_WIDTH*8-1:0]   buf_rd_data,
   output logic                    frame_done,
   output logic                    overflow
);

   localparam int WORD_W       = DQ_WIDTH * 8;
   localparam int PPW          = WORD_W / 16;
   localparam int LANE_W       = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);
   localparam int BEAT_W       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int FRAME_BURSTS = (H_WIDTH * H_HEIGHT) / (PPW * BURST_LEN);
   localparam int BC_W         = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;

   localparam logic [LANE_W-1:0] LANE_LAST   = LANE_W'(PPW - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST   = BEAT_W'(BURST_LEN - 1);
   localparam logic [BC_W-1:0]   BURST_LAST  = BC_W'(FRAME_BURSTS - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  CNT_BURST   = CNT_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(FRAME_BASE);
   localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DQ_WIDTH);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_XFER = 2'd2} state_t;

   // packer state
   logic [LANE_W-1:0]  r_lane;
   logic [WORD_W-1:0]  r_word;
   logic               r_push;
   logic [WORD_W-1:0]  r_push_word;
   logic [WORD_W-1:0]  w_full_word;

   // FIFO state
   logic [WORD_W-1:0]  r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [WORD_W-1:0]  r_rd_data;
   logic               r_overflow;
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;

   // burst control state
   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_req;
   logic               w_req_nxt;
   logic [BEAT_W-1:0]  r_beat;
   logic [BC_W-1:0]    r_burst;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_frame_done;
   logic               w_last_pop;

   assign w_full     = (r_count == CNT_FULL);
   assign w_empty    = (r_count == {CNT_W{1'b0}});
   assign w_push     = r_push && !w_full;
   assign w_pop      = buf_rd_en && (r_state == S_XFER) && !w_empty;
   assign w_last_pop = w_pop && (r_beat == BEAT_LAST);

   // Completed word: the buffered lanes plus the pixel arriving on the last lane.
   always_comb begin
      w_full_word                   = r_word;
      w_full_word[WORD_W-1 -: 16]   = pix_data;
   end

   // Packer: place pixels into lanes, stage a finished word for the FIFO, restart on vsync.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_lane      <= {LANE_W{1'b0}};
         r_word      <= {WORD_W{1'b0}};
         r_push      <= 1'b0;
         r_push_word <= {WORD_W{1'b0}};
      end else begin
         r_push <= 1'b0;
         if (pix_valid) begin
            if (vsync_i) begin
               // The pixel arriving with vsync is lane 0 of the new frame.
               r_word <= {{(WORD_W-16){1'b0}}, pix_data};
               r_lane <= LANE_W'(1);
            end else if (r_lane == LANE_LAST) begin
               r_push_word <= w_full_word;
               r_push      <= 1'b1;
               r_lane      <= {LANE_W{1'b0}};
            end else begin
               r_word[16*r_lane +: 16] <= pix_data;
               r_lane                  <= r_lane + LANE_W'(1);
            end
         end else if (vsync_i) begin
            r_lane <= {LANE_W{1'b0}};
         end
      end
   end

   // FIFO storage: written only when there is room; contents need no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= r_push_word;
      end
   end

   // FIFO pointers, occupancy, read register and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr   <= {PTR_W{1'b0}};
         r_rd_ptr   <= {PTR_W{1'b0}};
         r_count    <= {CNT_W{1'b0}};
         r_rd_data  <= {WORD_W{1'b0}};
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
            r_rd_data <= r_mem[r_rd_ptr];
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (r_push && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Burst FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Burst FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (r_count >= CNT_BURST) w_state_nxt = S_REQ;
            else                      w_state_nxt = S_IDLE;
         end
         S_REQ: begin
            if (axi_wr_ack) w_state_nxt = S_XFER;
            else            w_state_nxt = S_REQ;
         end
         S_XFER: begin
            if (w_last_pop) w_state_nxt = S_IDLE;
            else            w_state_nxt = S_XFER;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Burst FSM output decode, registered so the request is glitch-free.
   always_comb begin
      w_req_nxt = (w_state_nxt == S_REQ);
   end

   // Registered request, beat/burst counters, address advance and frame-end pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_req        <= 1'b0;
         r_beat       <= {BEAT_W{1'b0}};
         r_burst      <= {BC_W{1'b0}};
         r_addr       <= BASE_ADDR;
         r_frame_done <= 1'b0;
      end else begin
         r_req        <= w_req_nxt;
         r_frame_done <= 1'b0;
         if (w_pop) begin
            r_beat <= (r_beat == BEAT_LAST) ? {BEAT_W{1'b0}} : r_beat + BEAT_W'(1);
         end
         if (w_last_pop) begin
            if (r_burst == BURST_LAST) begin
               r_addr       <= BASE_ADDR;
               r_burst      <= {BC_W{1'b0}};
               r_frame_done <= 1'b1;
            end else begin
               r_addr  <= r_addr + BURST_BYTES;
               r_burst <= r_burst + BC_W'(1);
            end
         end
      end
   end

   assign axi_wr_req  = r_req;
   assign axi_wr_addr = r_addr;
   assign buf_rd_data = r_rd_data;
   assign frame_done  = r_frame_done;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_ddr_wr_buf.sv
// Directed bench for ddr_wr_buf using a reduced 256x6 frame (6 bursts per frame).
module tb_ddr_wr_buf;

   localparam int DQ_WIDTH   = 32;
   localparam int H_WIDTH    = 256;
   localparam int H_HEIGHT   = 6;
   localparam int BURST_LEN  = 16;
   localparam int FIFO_DEPTH = 64;
   localparam int ADDR_W     = 28;
   localparam int FRAME_BASE = 0;
   localparam int WORD_W     = DQ_WIDTH * 8;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                vsync_i = 1'b0;
   logic                pix_valid = 1'b0;
   logic [15:0]         pix_data = 16'd0;
   logic                axi_wr_req;
   logic [ADDR_W-1:0]   axi_wr_addr;
   logic                axi_wr_ack = 1'b0;
   logic                buf_rd_en = 1'b0;
   logic [WORD_W-1:0]   buf_rd_data;
   logic                frame_done;
   logic                overflow;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int                first_word;
      logic [ADDR_W-1:0] addr;
      logic [ADDR_W-1:0] next_addr;
      logic              fd;
   } burst_vec_t;

   burst_vec_t vecs [6];

   ddr_wr_buf #(
      .DQ_WIDTH(DQ_WIDTH), .H_WIDTH(H_WIDTH), .H_HEIGHT(H_HEIGHT),
      .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W),
      .FRAME_BASE(FRAME_BASE)
   ) dut (
      .clk(clk), .rst(rst), .vsync_i(vsync_i), .pix_valid(pix_valid),
      .pix_data(pix_data), .axi_wr_req(axi_wr_req), .axi_wr_addr(axi_wr_addr),
      .axi_wr_ack(axi_wr_ack), .buf_rd_en(buf_rd_en), .buf_rd_data(buf_rd_data),
      .frame_done(frame_done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Word w carries pixel values 16w .. 16w+15, lowest in bits [15:0].
   function automatic logic [WORD_W-1:0] exp_word(input int w);
      logic [WORD_W-1:0] r;
      r = '0;
      for (int j = 0; j < 16; j++) r[16*j +: 16] = 16'(16*w + j);
      return r;
   endfunction

   task automatic stream(input int start, input int n);
      for (int k = 0; k < n; k++) begin
         pix_valid = 1'b1;
         pix_data  = 16'(start + k);
         tick();
      end
      pix_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      vsync_i = 1'b0; pix_valid = 1'b0; axi_wr_ack = 1'b0; buf_rd_en = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (!axi_wr_req && n < 50) begin
         tick();
         n++;
      end
      chk("req_seen", {255'd0, axi_wr_req}, 256'd1);
   endtask

   task automatic serve_burst(input logic [ADDR_W-1:0] ea, input int fw,
                              input logic efd, input logic [ADDR_W-1:0] ena);
      wait_req();
      chk("req_addr", WORD_W'(axi_wr_addr), WORD_W'(ea));
      axi_wr_ack = 1'b1;
      tick();
      axi_wr_ack = 1'b0;
      chk("req_drop_after_ack", {255'd0, axi_wr_req}, 256'd0);
      for (int b = 0; b < BURST_LEN; b++) begin
         buf_rd_en = 1'b1;
         tick();
         chk("rd_data", buf_rd_data, exp_word(fw + b));
      end
      buf_rd_en = 1'b0;
      chk("frame_done", {255'd0, frame_done}, {255'd0, efd});
      chk("next_addr", WORD_W'(axi_wr_addr), WORD_W'(ena));
      tick();
      chk("frame_done_one_cycle", {255'd0, frame_done}, 256'd0);
   endtask

   initial begin
      vecs[0] = '{first_word: 0,  addr: 28'h000, next_addr: 28'h200, fd: 1'b0};
      vecs[1] = '{first_word: 16, addr: 28'h200, next_addr: 28'h400, fd: 1'b0};
      vecs[2] = '{first_word: 32, addr: 28'h400, next_addr: 28'h600, fd: 1'b0};
      vecs[3] = '{first_word: 48, addr: 28'h600, next_addr: 28'h800, fd: 1'b0};
      vecs[4] = '{first_word: 64, addr: 28'h800, next_addr: 28'hA00, fd: 1'b0};
      vecs[5] = '{first_word: 80, addr: 28'hA00, next_addr: 28'h000, fd: 1'b1};

      // Reset values while reset is held.
      repeat (2) tick();
      chk("rst_req", {255'd0, axi_wr_req}, 256'd0);
      chk("rst_addr", WORD_W'(axi_wr_addr), 256'd0);
      chk("rst_rd_data", buf_rd_data, 256'd0);
      chk("rst_frame_done", {255'd0, frame_done}, 256'd0);
      chk("rst_overflow", {255'd0, overflow}, 256'd0);
      rst = 1'b1;
      tick();

      // Whole frame, one table entry per burst.
      for (int i = 0; i < 6; i++) begin
         stream(vecs[i].first_word * 16, 16);
         repeat (3) tick();
         chk("no_req_one_word", {255'd0, axi_wr_req}, 256'd0);
         stream(vecs[i].first_word * 16 + 16, 240);
         serve_burst(vecs[i].addr, vecs[i].first_word, vecs[i].fd, vecs[i].next_addr);
      end
      // First burst of the next frame starts at the frame base again.
      stream(96 * 16, 256);
      serve_burst(28'h000, 96, 1'b0, 28'h200);

      // Overflow: 69 words with no service, 64 kept, later drained intact.
      do_reset();
      stream(0, 1024);
      repeat (2) tick();
      chk("ovf_not_yet", {255'd0, overflow}, 256'd0);
      chk("count_full", WORD_W'(dut.r_count), 256'd64);
      stream(1024, 80);
      repeat (2) tick();
      chk("ovf_set", {255'd0, overflow}, 256'd1);
      chk("count_still_full", WORD_W'(dut.r_count), 256'd64);
      for (int k = 0; k < 4; k++) begin
         serve_burst(ADDR_W'(k * 512), k * 16, 1'b0, ADDR_W'((k + 1) * 512));
         chk("count_after_drain", WORD_W'(dut.r_count), WORD_W'(64 - 16 * (k + 1)));
         chk("ovf_sticky", {255'd0, overflow}, 256'd1);
      end
      repeat (5) tick();
      chk("no_req_when_empty", {255'd0, axi_wr_req}, 256'd0);
      do_reset();
      chk("ovf_cleared_by_reset", {255'd0, overflow}, 256'd0);

      // vsync alone discards a partial word; vsync with a pixel makes it lane 0.
      stream(32'hA000, 7);
      vsync_i = 1'b1;
      tick();
      vsync_i = 1'b0;
      stream(0, 16);
      stream(32'hB000, 3);
      vsync_i = 1'b1; pix_valid = 1'b1; pix_data = 16'd16;
      tick();
      vsync_i = 1'b0; pix_valid = 1'b0;
      stream(17, 239);
      serve_burst(28'h000, 0, 1'b0, 28'h200);

      // Pixels keep streaming while a burst drains so a push meets a pop.
      do_reset();
      stream(0, 256);
      fork
         stream(256, 256);
         serve_burst(28'h000, 0, 1'b0, 28'h200);
      join
      repeat (2) tick();
      chk("count_push_pop", WORD_W'(dut.r_count), 256'd16);
      wait_req();
      chk("second_req_addr", WORD_W'(axi_wr_addr), 256'h200);

      // Reset in the middle of a burst.
      axi_wr_ack = 1'b1;
      tick();
      axi_wr_ack = 1'b0;
      buf_rd_en = 1'b1;
      repeat (3) tick();
      chk("mid_rd_data", buf_rd_data, exp_word(18));
      rst = 1'b0;
      buf_rd_en = 1'b0;
      tick();
      chk("mid_rst_req", {255'd0, axi_wr_req}, 256'd0);
      chk("mid_rst_addr", WORD_W'(axi_wr_addr), 256'd0);
      chk("mid_rst_rd_data", buf_rd_data, 256'd0);
      chk("mid_rst_count", WORD_W'(dut.r_count), 256'd0);
      rst = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
